// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side reports stage status; the controller side returns enables and counters.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch;
  logic        ex_pred_take;
  logic        ex_actual_take;
  logic        ex_ecall;
  logic        imem_busy;
  logic        dmem_busy;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        mem_wb_bubble;
  logic [1:0]  redirect_sel;
  logic [1:0]  state;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch, ex_pred_take, ex_actual_take, ex_ecall, imem_busy, dmem_busy,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
           mem_wb_bubble, redirect_sel, state, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch, ex_pred_take, ex_actual_take, ex_ecall, imem_busy, dmem_busy,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
           mem_wb_bubble, redirect_sel, state, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, mispredict flushes, trap drain
// and memory freezes, with saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TRAP_DRAIN_CYC = 2
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN        = 2'b00,
    MEM_WAIT   = 2'b01,
    TRAP_DRAIN = 2'b10
  } state_t;

  state_t     state_reg, state_next;
  state_t     saved_reg, saved_next;
  state_t     eff_state;
  logic [2:0] drain_reg, drain_next;
  logic       lu_prev_reg, lu_prev_next;

  logic [1:0][4:0] src_rs;
  logic [1:0]      src_use;
  logic [1:0]      src_hit;
  logic            mispredict;
  logic            load_use;

  logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_flush, id_ex_bubble, mem_wb_bubble;
  logic [1:0] redirect_sel;
  logic       mispredict_taken, trap_redirect;
  logic [1:0] count_inc;
  logic [31:0] count_val [2];

  assign src_rs  = {bus.id_rs2, bus.id_rs1};
  assign src_use = {bus.id_use_rs2, bus.id_use_rs1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_use[gi] && (src_rs[gi] == bus.ex_rd);
  end

  assign mispredict = bus.ex_branch && (bus.ex_pred_take != bus.ex_actual_take);
  // A stall just issued already moved the load out of EX, so never stall twice in a row.
  assign load_use   = bus.ex_mem_read && (bus.ex_rd != 5'd0) && (|src_hit) && !lu_prev_reg;

  always_comb begin
    if (rst)
      eff_state = RUN;
    else if (state_reg == MEM_WAIT)
      eff_state = saved_reg;
    else
      eff_state = state_reg;

    pc_en            = 1'b1;
    if_id_en         = 1'b1;
    id_ex_en         = 1'b1;
    ex_mem_en        = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    mem_wb_bubble    = 1'b0;
    redirect_sel     = 2'b00;
    mispredict_taken = 1'b0;
    trap_redirect    = 1'b0;
    state_next       = eff_state;
    saved_next       = saved_reg;
    drain_next       = drain_reg;
    lu_prev_next     = lu_prev_reg;

    if (bus.dmem_busy) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      state_next    = MEM_WAIT;
      if (state_reg != MEM_WAIT)
        saved_next = state_reg;
    end else begin
      lu_prev_next = 1'b0;
      if (eff_state == TRAP_DRAIN) begin
        pc_en        = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (drain_reg <= 3'd1) begin
          pc_en         = 1'b1;
          redirect_sel  = 2'b10;
          trap_redirect = 1'b1;
          drain_next    = 3'd0;
          state_next    = RUN;
        end else begin
          drain_next = drain_reg - 3'd1;
          state_next = TRAP_DRAIN;
        end
      end else if (bus.ex_ecall) begin
        pc_en        = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_en    = 1'b1;
        drain_next   = 3'(TRAP_DRAIN_CYC);
        state_next   = TRAP_DRAIN;
      end else if (mispredict) begin
        // Wrong-path ID instruction: flush wins over any load-use dependency it carries.
        if_id_flush      = 1'b1;
        id_ex_bubble     = 1'b1;
        redirect_sel     = 2'b01;
        mispredict_taken = 1'b1;
      end else if (load_use) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        lu_prev_next = 1'b1;
      end else if (bus.imem_busy) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RUN;
      saved_reg   <= RUN;
      drain_reg   <= 3'd0;
      lu_prev_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      saved_reg   <= saved_next;
      drain_reg   <= drain_next;
      lu_prev_reg <= lu_prev_next;
    end
  end

  // Index 0 counts stall cycles, index 1 counts flush events.
  assign count_inc = {mispredict_taken | trap_redirect, ~pc_en};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [31:0] count_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        count_reg <= 32'd0;
      else if (count_inc[gi] && (count_reg != 32'hFFFF_FFFF))
        count_reg <= count_reg + 32'd1;
    end
    assign count_val[gi] = count_reg;
  end

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.ex_mem_en     = ex_mem_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.redirect_sel  = redirect_sel;
  assign bus.state         = state_reg;
  assign bus.stall_count   = count_val[0];
  assign bus.flush_count   = count_val[1];
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios followed by random stimulus, all checked against a rule-level
// model of the hazard controller kept in the bench.
module tb_pipeline_hazard_ctrl;
  localparam int TRAP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.TRAP_DRAIN_CYC(TRAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state: mode 0 = running, 1 = frozen on data memory, 2 = draining a trap.
  int          m_mode, m_saved, m_drain;
  bit          m_stalled_last;
  logic [31:0] m_stalls, m_flushes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_mode = 0; m_saved = 0; m_drain = 0; m_stalled_last = 0;
    m_stalls = 0; m_flushes = 0;
  endtask

  task automatic clear_inputs();
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_rd = 0; bus.ex_mem_read = 0; bus.ex_branch = 0; bus.ex_pred_take = 0;
    bus.ex_actual_take = 0; bus.ex_ecall = 0; bus.imem_busy = 0; bus.dmem_busy = 0;
  endtask

  // Packing: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble, mem_wb_bubble, redirect_sel}
  task automatic model_eval(output logic [8:0] ctl, output int n_mode, output int n_saved,
                            output int n_drain, output bit n_stalled, output bit inc_s,
                            output bit inc_f);
    int eff;
    bit pc, ifid, idex, exmem, fl, bub, wb, dep, mis;
    logic [1:0] red;
    pc = 1; ifid = 1; idex = 1; exmem = 1; fl = 0; bub = 0; wb = 0; red = 2'b00;
    inc_f = 0;
    n_mode = m_mode; n_saved = m_saved; n_drain = m_drain; n_stalled = m_stalled_last;
    eff = (m_mode == 1) ? m_saved : m_mode;
    mis = bus.ex_branch && (bus.ex_pred_take != bus.ex_actual_take);
    dep = bus.ex_mem_read && bus.ex_rd != 0 &&
          ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    if (bus.dmem_busy) begin
      pc = 0; ifid = 0; idex = 0; exmem = 0; wb = 1;
      if (m_mode != 1) n_saved = m_mode;
      n_mode = 1;
    end else begin
      n_stalled = 0;
      n_mode = eff;
      if (eff == 2) begin
        fl = 1; bub = 1;
        if (m_drain == 1) begin
          pc = 1; red = 2'b10; inc_f = 1; n_mode = 0; n_drain = 0;
        end else begin
          pc = 0; n_drain = m_drain - 1;
        end
      end else if (bus.ex_ecall) begin
        pc = 0; fl = 1; bub = 1; n_drain = TRAP; n_mode = 2;
      end else if (mis) begin
        fl = 1; bub = 1; red = 2'b01; inc_f = 1;
      end else if (dep && !m_stalled_last) begin
        pc = 0; ifid = 0; bub = 1; n_stalled = 1;
      end else if (bus.imem_busy) begin
        pc = 0; fl = 1;
      end
    end
    inc_s = !pc;
    ctl = {pc, ifid, idex, exmem, fl, bub, wb, red};
  endtask

  function automatic logic [8:0] dut_ctl();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.if_id_flush,
            bus.id_ex_bubble, bus.mem_wb_bubble, bus.redirect_sel};
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string what);
    logic [8:0] e_ctl;
    int nm, ns, nd;
    bit nst, is, ifl;
    if (rst) model_reset();
    #1;
    model_eval(e_ctl, nm, ns, nd, nst, is, ifl);
    check({what, ":ctl"}, 32'(dut_ctl()), 32'(e_ctl));
    check({what, ":state"}, 32'(bus.state), 32'(m_mode));
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else begin
      m_mode = nm; m_saved = ns; m_drain = nd; m_stalled_last = nst;
      if (is && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (ifl && m_flushes != 32'hFFFF_FFFF) m_flushes++;
    end
    check({what, ":stall_count"}, bus.stall_count, m_stalls);
    check({what, ":flush_count"}, bus.flush_count, m_flushes);
    $display("[%0d] %s rst=%0b ctl=%b state=%0d stalls=%0d flushes=%0d",
             cyc, what, rst, e_ctl, bus.state, bus.stall_count, bus.flush_count);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    step("reset");
    step("reset");
    rst = 1'b0;
    step("idle");

    // Single-cycle load-use stall
    bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_use_rs1 = 1;
    step("load_use");
    clear_inputs();
    step("after_lu");
    check("lu_stall_total", bus.stall_count, 32'd1);

    // Same dependency on x0 never stalls
    bus.ex_mem_read = 1; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_use_rs1 = 1;
    step("lu_x0");
    check("x0_no_stall", bus.stall_count, 32'd1);

    // Mispredict overrides a simultaneous load-use
    bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_use_rs1 = 1;
    bus.ex_branch = 1; bus.ex_pred_take = 0; bus.ex_actual_take = 1;
    step("mispredict_lu");
    check("mis_flush_total", bus.flush_count, 32'd1);
    clear_inputs();

    // Instruction memory stall
    bus.imem_busy = 1;
    step("imem_busy");
    clear_inputs();

    // ecall and trap drain
    bus.ex_ecall = 1;
    step("ecall");
    bus.ex_ecall = 0;
    step("drain1");
    check("drain_redirect", 32'(bus.redirect_sel), 32'd2);
    step("drain2");
    step("after_trap");

    // Data memory freeze during the first drain cycle
    bus.ex_ecall = 1;
    step("ecall_b");
    bus.ex_ecall = 0;
    bus.dmem_busy = 1;
    for (int i = 0; i < 3; i++) step("freeze");
    bus.dmem_busy = 0;
    step("resume");
    step("resume_redirect");
    step("after_freeze");

    // Reset aborts a trap drain
    bus.ex_ecall = 1;
    step("ecall_c");
    rst = 1'b1;
    check("rst_no_trap_redirect", 32'(bus.redirect_sel == 2'b10), 32'd0);
    step("rst_abort");
    rst = 1'b0;
    bus.ex_ecall = 0;
    step("post_rst");
    check("rst_state_run", 32'(bus.state), 32'd0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      bus.id_rs1         = 5'($urandom_range(3));
      bus.id_rs2         = 5'($urandom_range(3));
      bus.id_use_rs1     = 1'($urandom_range(1));
      bus.id_use_rs2     = 1'($urandom_range(1));
      bus.ex_rd          = 5'($urandom_range(3));
      bus.ex_mem_read    = ($urandom_range(2) == 0);
      bus.ex_branch      = ($urandom_range(2) == 0);
      bus.ex_pred_take   = 1'($urandom_range(1));
      bus.ex_actual_take = 1'($urandom_range(1));
      bus.ex_ecall       = ($urandom_range(11) == 0);
      bus.imem_busy      = ($urandom_range(4) == 0);
      bus.dmem_busy      = ($urandom_range(5) == 0);
      rst                = ($urandom_range(79) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
